dmem_hs: RTL and testbench

//   Parametrised byte-addressable data memory with valid/ready request and response channels.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 39 +++
 rtl/dmem_hs.sv | 134 +++++++++++++
 tb/tb_dmem_hs.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the dmem_hs data memory.
package dmem_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Ceiling log2; returns 0 for v <= 1
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-wide storage for dmem_hs: per-lane write strobes, combinational word read.
// Contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_SIZE  = 128,
    parameter int unsigned DATA_W    = 32,
    parameter string       INIT_FILE = "",
    parameter int unsigned AW        = clog2(MEM_SIZE)
) (
    input  logic                clk,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [AW-1:0]       base,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    localparam int unsigned LANES = DATA_W / 8;

    logic [7:0] mem [MEM_SIZE];

    // Byte-lane writes at base+i
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wstrb[i]) begin
                mem[base + AW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    // Word read at base; callers gate the result on error
    always_comb begin
        rdata = '0;
        for (int i = 0; i < LANES; i++) begin
            rdata[8*i +: 8] = mem[base + AW'(i)];
        end
    end

endmodule

// File: rtl/dmem_hs.sv
// Byte-addressable data memory with valid/ready request and response channels,
// fixed read/write latency, response backpressure and range error reporting.
// Optional macro DMEM_HS_ALIGN_CHK_EN: misaligned addresses report an error
// instead of being silently aligned down.
module dmem_hs
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_SIZE  = 128,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RD_LAT    = 1,
    parameter string       INIT_FILE = "mem.hex"
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_W/8-1:0] req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned AW    = clog2(MEM_SIZE);

    logic [1:0]          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [ADDR_W-1:0]   base;
    logic                err_range;
    logic                err;
    logic                accept;
    logic                rsp_done;
    logic [LANES-1:0]    wstrb;
    logic [DATA_W-1:0]   rd_word;

    assign base = req_addr & ~ADDR_W'(LANES - 1);
    // Compare against the last legal base so a base near the top of the
    // address space cannot wrap around and look in range.
    assign err_range = base > ADDR_W'(MEM_SIZE - LANES);

`ifdef DMEM_HS_ALIGN_CHK_EN
    assign err = err_range | ((req_addr & ADDR_W'(LANES - 1)) != '0);
`else
    assign err = err_range;
`endif

    assign req_ready = rst_n & (state_q == IDLE);
    assign accept    = req_valid & req_ready;
    assign rsp_valid = (state_q == RESP);
    assign rsp_done  = rsp_valid & rsp_ready;
    assign wstrb     = (accept && !err) ? req_we : '0;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    dmem_array #(
        .MEM_SIZE  (MEM_SIZE),
        .DATA_W    (DATA_W),
        .INIT_FILE (INIT_FILE),
        .AW        (AW)
    ) u_array (
        .clk   (clk),
        .wstrb (wstrb),
        .base  (base[AW-1:0]),
        .wdata (req_wdata),
        .rdata (rd_word)
    );

    // Next-state: FSM, latency counter and response capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Word sampled now so later writes cannot disturb it
                    rdata_d = (err || (req_we != '0)) ? '0 : rd_word;
                    err_d   = err;
                    if (RD_LAT == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(RD_LAT - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_done) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                rdata_d = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    // State registers; reset drops any pending response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dmem_hs.sv
// Randomised scoreboard bench for dmem_hs (RD_LAT=3, 128 bytes, 32-bit words).
module tb_dmem_hs;

    localparam int unsigned MEM_SIZE = 128;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned RD_LAT   = 3;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   bp_mode = 0;  // 0 random ready, 1 hold low, 2 hold high
    logic prev_valid = 1'b0;
    logic [7:0] ref_mem [MEM_SIZE];
    exp_t q [$];

    dmem_hs #(
        .MEM_SIZE  (MEM_SIZE),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .RD_LAT    (RD_LAT),
        .INIT_FILE ("")
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: rules applied directly to a byte array
    function automatic exp_t model(input logic [3:0] we, input logic [31:0] addr,
                                   input logic [31:0] wd);
        exp_t e;
        longint unsigned base;
        logic bad;
        base = longint'(addr) - longint'(addr % 4);
        bad  = (base + 4 > MEM_SIZE);
`ifdef DMEM_HS_ALIGN_CHK_EN
        if (addr % 4 != 0) bad = 1'b1;
`endif
        e.err  = bad;
        e.data = 32'h0;
        e.acc  = 0;
        if (!bad) begin
            if (we == 4'h0) begin
                for (int i = 0; i < 4; i++) e.data[8*i +: 8] = ref_mem[int'(base) + i];
            end else begin
                for (int i = 0; i < 4; i++)
                    if (we[i]) ref_mem[int'(base) + i] = wd[8*i +: 8];
            end
        end
        return e;
    endfunction

    // Issue one request; kd/ke override the model when use_k is set
    task automatic do_req(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd,
                          input bit use_k, input logic [31:0] kd, input logic ke,
                          input bit wait_rsp);
        exp_t e;
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 32'(req_ready), 32'h1);
            req_valid = 1'b0;
            return;
        end
        e = model(we, addr, wd);
        if (use_k) begin
            e.data = kd;
            e.err  = ke;
        end
        e.acc = cyc + 1;
        q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (wait_rsp) begin
            n = 0;
            while (q.size() != 0 && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (q.size() != 0) begin
                chk("rsp_timeout", 32'(q.size()), 32'h0);
                q.delete();
            end
        end
    endtask

    // Response-ready driver, changed just after the active edge
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                1:       rsp_ready = 1'b0;
                2:       rsp_ready = 1'b1;
                default: rsp_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compares the response channel against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rsp_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
                    end else begin
                        if (!prev_valid) chk("latency", 32'(cyc - q[0].acc), 32'(RD_LAT - 1));
                        chk("rsp_rdata", rsp_rdata, q[0].data);
                        chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
                        chk("busy_ready", 32'(req_ready), 32'h0);
                        if (rsp_ready) void'(q.pop_front());
                    end
                end else if (req_ready) begin
                    chk("idle_rdata", rsp_rdata, 32'h0);
                    chk("idle_err", 32'(rsp_err), 32'h0);
                end
                prev_valid = rsp_valid;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] a;
        logic [3:0]  w;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset holds both handshake outputs low
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_req_ready", 32'(req_ready), 32'h0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'h1);

        // Give every byte a known value
        for (int i = 0; i < int'(MEM_SIZE); i += 4)
            do_req(4'hF, 32'(i), $urandom, 1'b0, 32'h0, 1'b0, 1'b1);

        do_req(4'hF, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 1'b1);
        do_req(4'h0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
        do_req(4'b0100, 32'h10, 32'h00AA0000, 1'b1, 32'h0, 1'b0, 1'b1);
        do_req(4'h0, 32'h10, 32'h0, 1'b1, 32'hDEAABEEF, 1'b0, 1'b1);

        do_req(4'hF, 32'h80, 32'h12345678, 1'b1, 32'h0, 1'b1, 1'b1);
        do_req(4'h0, 32'h7C, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        do_req(4'h0, 32'hFFFFFFFC, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
`ifdef DMEM_HS_ALIGN_CHK_EN
        do_req(4'h0, 32'h13, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
        do_req(4'hF, 32'h11, 32'h55555555, 1'b1, 32'h0, 1'b1, 1'b1);
`else
        do_req(4'h0, 32'h13, 32'h0, 1'b1, 32'hDEAABEEF, 1'b0, 1'b1);
`endif
        do_req(4'h0, 32'h10, 32'h0, 1'b1, 32'hDEAABEEF, 1'b0, 1'b1);

        // Backpressure: response held stable for 5 cycles
        bp_mode = 1;
        do_req(4'h0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", 32'(rsp_valid), 32'h1);
        repeat (5) @(negedge clk);
        bp_mode = 2;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_valid", 32'(rsp_valid), 32'h0);
        chk("bp_release_ready", 32'(req_ready), 32'h1);
        bp_mode = 0;

        // Reset during WAIT drops the response
        do_req(4'h0, 32'h20, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_ready", 32'(req_ready), 32'h0);
            chk("midrst_valid", 32'(rsp_valid), 32'h0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("dropped_rsp", 32'(rsp_valid), 32'h0);
        end

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'h80 + $urandom_range(0, 127);
                1:       a = 32'hFFFFFFF0 + $urandom_range(0, 15);
                default: a = $urandom_range(0, MEM_SIZE - 1);
            endcase
            w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            do_req(w, a, $urandom, 1'b0, 32'h0, 1'b0, 1'b1);
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
